alarm_trigger_cond: RTL and testbench

//  Alarm-clock trigger condition. Stores a programmed alarm time (hh:mm:ss) and

---
 rtl/alarm_trigger_cond_if.sv | 35 +++
 rtl/alarm_trigger_cond.sv | 141 ++++++++++++++
 tb/tb_alarm_trigger_cond.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_trigger_cond_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alarm_trigger_cond_if                                      |
// | Description : RTC time, alarm programming, PIN acknowledge and ringing   |
// |               output bundle for the alarm trigger condition block.       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface alarm_trigger_cond_if;
  logic [4:0] hour_rtc;
  logic [5:0] min_rtc;
  logic [5:0] sec_rtc;
  logic       alarm_set;
  logic [4:0] alarm_hour_in;
  logic [5:0] alarm_min_in;
  logic [5:0] alarm_sec_in;
  logic       pin_check;
  logic       alarm_active;

  // Driver side: RTC block, keypad/PIN logic and the programming path.
  modport master (
    output hour_rtc, min_rtc, sec_rtc,
    output alarm_set, alarm_hour_in, alarm_min_in, alarm_sec_in,
    output pin_check,
    input  alarm_active
  );

  // Alarm trigger block side.
  modport slave (
    input  hour_rtc, min_rtc, sec_rtc,
    input  alarm_set, alarm_hour_in, alarm_min_in, alarm_sec_in,
    input  pin_check,
    output alarm_active
  );
endinterface
`default_nettype wire

// File: rtl/alarm_trigger_cond.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alarm_trigger_cond                                         |
// | Description : Stores a programmed hh:mm:ss alarm time, compares it each  |
// |               clock against the RTC and rings until PIN acknowledge or   |
// |               ring timeout (counted in RTC seconds).                     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module alarm_trigger_cond #(
  parameter int RING_TIMEOUT_S = 60
) (
  input  wire logic           clk,
  input  wire logic           rst,   // asynchronous, active-low
  alarm_trigger_cond_if.slave bus
);

  localparam int c_cnt_w = (RING_TIMEOUT_S > 1) ? $clog2(RING_TIMEOUT_S + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_timeout    = c_cnt_w'(RING_TIMEOUT_S);
  localparam logic               c_timeout_en = (RING_TIMEOUT_S != 0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_cnt_w-1:0] r_ring_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic [c_cnt_w-1:0] w_cnt_inc;
  logic               r_alarm_active;

  logic [4:0]         r_alarm_h;
  logic [5:0]         r_alarm_m;
  logic [5:0]         r_alarm_s;
  logic               r_match_q;
  logic [5:0]         r_sec_q;

  logic               w_set_valid;
  logic               w_match;
  logic               w_match_new;
  logic               w_trigger;
  logic               w_sec_tick;

  // Range check of the programming strobe; out-of-range fields void the whole load.
  assign w_set_valid = bus.alarm_set
                     && (bus.alarm_hour_in <= 5'd23)
                     && (bus.alarm_min_in  <= 6'd59)
                     && (bus.alarm_sec_in  <= 6'd59);

  // Match against the stored alarm (old value on a load edge) and against the
  // incoming value, the latter only to seed the edge detector on a load.
  assign w_match     = (bus.hour_rtc == r_alarm_h) && (bus.min_rtc == r_alarm_m)
                     && (bus.sec_rtc == r_alarm_s);
  assign w_match_new = (bus.hour_rtc == bus.alarm_hour_in)
                     && (bus.min_rtc == bus.alarm_min_in)
                     && (bus.sec_rtc == bus.alarm_sec_in);
  assign w_trigger   = w_match && !r_match_q;
  assign w_sec_tick  = (r_sec_q != bus.sec_rtc);
  assign w_cnt_inc   = r_ring_cnt + 1'b1;

  assign bus.alarm_active = r_alarm_active;

  // Next-state and ring counter: load > PIN acknowledge > timeout > trigger.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_ring_cnt;
    if (w_set_valid) begin
      w_state_nxt = ST_ARMED;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_IDLE;
        end
        ST_ARMED: begin
          if (w_trigger) begin
            w_state_nxt = ST_RINGING;
            w_cnt_nxt   = '0;
          end
        end
        ST_RINGING: begin
          if (bus.pin_check) begin
            w_state_nxt = ST_ARMED;
            w_cnt_nxt   = '0;
          end else if (w_sec_tick) begin
            if (c_timeout_en && (w_cnt_inc == c_timeout)) begin
              w_state_nxt = ST_ARMED;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State, ring counter and the registered ringing output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_IDLE;
      r_ring_cnt     <= '0;
      r_alarm_active <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_ring_cnt     <= w_cnt_nxt;
      r_alarm_active <= (w_state_nxt == ST_RINGING);
    end
  end

  // Stored alarm time, match edge detector and delayed seconds copy.
  // On a load the edge detector is seeded with the match against the new
  // time, so programming the current RTC time waits for its next occurrence.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alarm_h <= '0;
      r_alarm_m <= '0;
      r_alarm_s <= '0;
      r_match_q <= 1'b0;
      r_sec_q   <= '0;
    end else begin
      r_sec_q <= bus.sec_rtc;
      if (w_set_valid) begin
        r_alarm_h <= bus.alarm_hour_in;
        r_alarm_m <= bus.alarm_min_in;
        r_alarm_s <= bus.alarm_sec_in;
        r_match_q <= w_match_new;
      end else begin
        r_match_q <= w_match;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alarm_trigger_cond.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_alarm_trigger_cond                                      |
// | Description : Directed self-checking bench; dut_a uses the default ring  |
// |               timeout, dut_b a 2-second timeout, both on shared stimulus.|
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_alarm_trigger_cond;

  logic       clk;
  logic       rst;
  logic [4:0] hour_rtc;
  logic [5:0] min_rtc;
  logic [5:0] sec_rtc;
  logic       alarm_set;
  logic [4:0] alarm_hour_in;
  logic [5:0] alarm_min_in;
  logic [5:0] alarm_sec_in;
  logic       pin_check;

  int n_total;
  int n_pass;

  alarm_trigger_cond_if if_a ();
  alarm_trigger_cond_if if_b ();

  // Same stimulus fans out to both instances.
  assign if_a.hour_rtc      = hour_rtc;
  assign if_a.min_rtc       = min_rtc;
  assign if_a.sec_rtc       = sec_rtc;
  assign if_a.alarm_set     = alarm_set;
  assign if_a.alarm_hour_in = alarm_hour_in;
  assign if_a.alarm_min_in  = alarm_min_in;
  assign if_a.alarm_sec_in  = alarm_sec_in;
  assign if_a.pin_check     = pin_check;
  assign if_b.hour_rtc      = hour_rtc;
  assign if_b.min_rtc       = min_rtc;
  assign if_b.sec_rtc       = sec_rtc;
  assign if_b.alarm_set     = alarm_set;
  assign if_b.alarm_hour_in = alarm_hour_in;
  assign if_b.alarm_min_in  = alarm_min_in;
  assign if_b.alarm_sec_in  = alarm_sec_in;
  assign if_b.pin_check     = pin_check;

  alarm_trigger_cond dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a.slave)
  );

  alarm_trigger_cond #(.RING_TIMEOUT_S(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic got, input logic exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b at %0t", tag, got, exp, $time);
  endtask

  // Advance one clock; inputs driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rtc(input int h, input int m, input int s);
    hour_rtc = 5'(h);
    min_rtc  = 6'(m);
    sec_rtc  = 6'(s);
  endtask

  task automatic do_set(input int h, input int m, input int s);
    alarm_set     = 1'b1;
    alarm_hour_in = 5'(h);
    alarm_min_in  = 6'(m);
    alarm_sec_in  = 6'(s);
    step();
    alarm_set     = 1'b0;
  endtask

  initial begin
    n_total       = 0;
    n_pass        = 0;
    rst           = 1'b0;
    alarm_set     = 1'b0;
    alarm_hour_in = '0;
    alarm_min_in  = '0;
    alarm_sec_in  = '0;
    pin_check     = 1'b0;
    set_rtc(0, 0, 0);

    // Reset state.
    #50;
    check_val("reset_a", if_a.alarm_active, 1'b0);
    check_val("reset_b", if_b.alarm_active, 1'b0);
    step();
    rst = 1'b1;

    // Power-up 00:00:00 is never treated as a programmed alarm.
    for (int s = 0; s <= 5; s++) begin
      set_rtc(0, 0, s);
      step();
      check_val("idle_no_fire_a", if_a.alarm_active, 1'b0);
      check_val("idle_no_fire_b", if_b.alarm_active, 1'b0);
    end

    // Alarm at 01:02:03 does not fire at 00:00:0x; PIN while armed has no effect.
    do_set(1, 2, 3);
    for (int s = 0; s <= 5; s++) begin
      set_rtc(0, 0, s);
      step();
      check_val("armed_other_time", if_a.alarm_active, 1'b0);
    end
    pin_check = 1'b1;
    step();
    check_val("pin_while_armed", if_a.alarm_active, 1'b0);
    pin_check = 1'b0;

    // Alarm at 00:00:03; dut_b times out after two second changes.
    set_rtc(0, 0, 0);
    step();
    do_set(0, 0, 3);
    for (int s = 1; s <= 5; s++) begin
      set_rtc(0, 0, s);
      step();
      check_val("ring_a", if_a.alarm_active, (s >= 3));
      check_val("ring_timeout_b", if_b.alarm_active, (s == 3) || (s == 4));
    end
    pin_check = 1'b1;
    step();
    check_val("pin_silence", if_a.alarm_active, 1'b0);
    pin_check = 1'b0;
    step();
    check_val("pin_stays_off", if_a.alarm_active, 1'b0);

    // Re-occurrence fires (dut_b proves it returned to ARMED after timeout);
    // after PIN no retrigger while the time still matches.
    set_rtc(0, 0, 2);
    step();
    set_rtc(0, 0, 3);
    step();
    check_val("refire_a", if_a.alarm_active, 1'b1);
    check_val("refire_after_timeout_b", if_b.alarm_active, 1'b1);
    pin_check = 1'b1;
    step();
    check_val("pin_silence2_a", if_a.alarm_active, 1'b0);
    check_val("pin_silence2_b", if_b.alarm_active, 1'b0);
    pin_check = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("no_retrigger", if_a.alarm_active, 1'b0);
    end

    // PIN held high while armed does not block a trigger, then silences it.
    set_rtc(0, 0, 2);
    pin_check = 1'b1;
    step();
    set_rtc(0, 0, 3);
    step();
    check_val("pin_held_trigger", if_a.alarm_active, 1'b1);
    step();
    check_val("pin_held_silence", if_a.alarm_active, 1'b0);
    pin_check = 1'b0;

    // Valid load while ringing drops the alarm at once.
    set_rtc(0, 0, 2);
    step();
    set_rtc(0, 0, 3);
    step();
    check_val("ring_before_load", if_a.alarm_active, 1'b1);
    do_set(0, 0, 9);
    check_val("load_from_ringing", if_a.alarm_active, 1'b0);

    // Load beats a trigger on the same edge; new value compared from next cycle.
    set_rtc(0, 0, 8);
    step();
    set_rtc(0, 0, 9);
    do_set(0, 0, 20);
    check_val("load_beats_trigger", if_a.alarm_active, 1'b0);
    step();
    check_val("old_value_dropped", if_a.alarm_active, 1'b0);
    set_rtc(0, 0, 20);
    step();
    check_val("new_value_fires", if_a.alarm_active, 1'b1);
    pin_check = 1'b1;
    step();
    pin_check = 1'b0;

    // Programming the current RTC time waits for its next occurrence.
    set_rtc(0, 0, 21);
    step();
    do_set(0, 0, 21);
    step();
    check_val("reprog_now_1", if_a.alarm_active, 1'b0);
    step();
    check_val("reprog_now_2", if_a.alarm_active, 1'b0);
    set_rtc(0, 0, 22);
    step();
    set_rtc(0, 0, 21);
    step();
    check_val("reprog_next_occ", if_a.alarm_active, 1'b1);
    pin_check = 1'b1;
    step();
    pin_check = 1'b0;

    // Out-of-range loads are ignored; the 00:00:21 alarm still fires.
    do_set(24, 0, 0);
    do_set(0, 60, 0);
    do_set(0, 0, 60);
    check_val("bad_load_quiet", if_a.alarm_active, 1'b0);
    set_rtc(0, 0, 20);
    step();
    set_rtc(0, 0, 21);
    step();
    check_val("bad_load_ignored_a", if_a.alarm_active, 1'b1);
    check_val("bad_load_ignored_b", if_b.alarm_active, 1'b1);

    // Asynchronous reset mid-ring clears the output without a clock edge.
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_val("async_reset_a", if_a.alarm_active, 1'b0);
    check_val("async_reset_b", if_b.alarm_active, 1'b0);
    #10;
    rst = 1'b1;
    step();
    set_rtc(0, 0, 20);
    step();
    set_rtc(0, 0, 21);
    step();
    check_val("disarmed_old_time_a", if_a.alarm_active, 1'b0);
    check_val("disarmed_old_time_b", if_b.alarm_active, 1'b0);
    set_rtc(0, 0, 0);
    step();
    check_val("disarmed_midnight", if_a.alarm_active, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
